// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Per-register result scoreboard for an in-order pipeline.
//             Tracks fixed-latency results with down-counters and
//             variable-latency results with a pending flag, and raises a
//             stall/bubble when the instruction in ID reads a result that is
//             not yet forwardable, or would overwrite a pending
//             variable-latency destination.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 3,
   localparam int RA_W    = $clog2(NUM_REGS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ID_Valid_i,
   input  logic [6:0]          ID_Opcode_i,
   input  logic [RA_W-1:0]     ID_Rs1_i,
   input  logic [RA_W-1:0]     ID_Rs2_i,
   input  logic [RA_W-1:0]     ID_Rd_i,
   input  logic                ID_RegWrite_i,
   input  logic [LAT_W-1:0]    ID_Latency_i,
   input  logic                ID_VarLat_i,
   input  logic                Flush_i,
   input  logic                WB_Done_i,
   input  logic [RA_W-1:0]     WB_Rd_i,
   output logic                NoOp_o,
   output logic                Stall_o,
   output logic                PCWrite_o,
   output logic [NUM_REGS-1:0] Busy_o,
   output logic [15:0]         StallCount_o
);

   // Opcodes that decide whether rs1 / rs2 are actually read
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_RTYPEW = 7'b0111011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

   logic [LAT_W-1:0]    cnt_q [NUM_REGS];
   logic [LAT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] varlat_q;
   logic [NUM_REGS-1:0] varlat_d;
   logic [15:0]         stall_cnt_q;
   logic [15:0]         stall_cnt_d;

   logic [NUM_REGS-1:0] busy;
   logic                rs1_used;
   logic                rs2_used;
   logic                hazard;
   logic                issue;

   // x0 is hard-wired and can never hold a pending result
   assign busy[0] = 1'b0;

   // A pending variable-latency result is treated as ready in its completion
   // cycle so that the WB value can be forwarded without an extra bubble
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_busy
      assign busy[r] = (cnt_q[r] != '0)
                     | (varlat_q[r] & ~(WB_Done_i & (WB_Rd_i == RA_W'(r))));
   end

   assign rs1_used = ~((ID_Opcode_i == c_OP_LUI)   |
                       (ID_Opcode_i == c_OP_AUIPC) |
                       (ID_Opcode_i == c_OP_JAL));
   assign rs2_used =  (ID_Opcode_i == c_OP_RTYPE)  |
                      (ID_Opcode_i == c_OP_RTYPEW) |
                      (ID_Opcode_i == c_OP_STORE)  |
                      (ID_Opcode_i == c_OP_BRANCH);

   // The last term blocks a WAW against an outstanding variable-latency write
   assign hazard = ID_Valid_i &
                   ((rs1_used & busy[ID_Rs1_i]) |
                    (rs2_used & busy[ID_Rs2_i]) |
                    (ID_RegWrite_i & varlat_q[ID_Rd_i] & busy[ID_Rd_i]));

   // Flush only kills the issue; the hazard outputs are still reported
   assign issue = ID_Valid_i & ~hazard & ~Flush_i & ID_RegWrite_i & (ID_Rd_i != '0);

   assign NoOp_o       = hazard;
   assign Stall_o      = hazard;
   assign PCWrite_o    = ~hazard;
   assign Busy_o       = busy;
   assign StallCount_o = stall_cnt_q;

   // Next-state: age counters, retire completions, then let a new issue win
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
      end
      varlat_d = varlat_q;
      if (WB_Done_i) begin
         varlat_d[WB_Rd_i] = 1'b0;
      end
      if (issue) begin
         if (ID_VarLat_i) begin
            varlat_d[ID_Rd_i] = 1'b1;
            cnt_d[ID_Rd_i]    = '0;
         end else begin
            cnt_d[ID_Rd_i]    = ID_Latency_i;
         end
      end
      stall_cnt_d = stall_cnt_q;
      if (hazard && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State registers; reset discards every pending entry and the stall count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         varlat_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         varlat_q    <= varlat_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard. A cycle-indexed
//             reference model (ready-cycle per register plus pending flags)
//             predicts every output; directed vectors and sequences cover
//             the latency, WB-forwarding, WAW, flush and reset corners.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

   localparam int NR = 32;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_ADD   = 7'b0110011;
   localparam logic [6:0] OP_ADDW  = 7'b0111011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_ADDI  = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [6:0]  op;
   logic [4:0]  rs1, rs2, rd;
   logic        regwrite;
   logic [2:0]  lat;
   logic        varlat, flush, wb;
   logic [4:0]  wbrd;
   logic        noop, stall, pcw;
   logic [31:0] busy;
   logic [15:0] scnt;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(NR), .LAT_W(3)) dut (
      .clk_i(clk), .rst_i(rst),
      .ID_Valid_i(valid), .ID_Opcode_i(op),
      .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .ID_Rd_i(rd),
      .ID_RegWrite_i(regwrite), .ID_Latency_i(lat), .ID_VarLat_i(varlat),
      .Flush_i(flush), .WB_Done_i(wb), .WB_Rd_i(wbrd),
      .NoOp_o(noop), .Stall_o(stall), .PCWrite_o(pcw),
      .Busy_o(busy), .StallCount_o(scnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a register is forwardable from cycle ready[r] on;
   // pend[r] marks an outstanding variable-latency result.
   int cyc = 0;
   int ready [NR];
   bit pend  [NR];
   int m_scnt = 0;

   typedef struct {
      logic       valid;
      logic [6:0] op;
      logic [4:0] rs1, rs2, rd;
      logic       regwrite, flush, wb;
      logic [4:0] wbrd;
      logic       exp_stall;
   } vec_t;

   vec_t       vt [15];
   logic [6:0] ops [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit m_busy(input int r);
      if (r == 0) return 1'b0;
      if (cyc < ready[r]) return 1'b1;
      return pend[r] && !(wb && (int'(wbrd) == r));
   endfunction

   function automatic logic [31:0] m_busyvec();
      logic [31:0] v;
      for (int r = 0; r < NR; r++) v[r] = m_busy(r);
      return v;
   endfunction

   function automatic bit m_hazard();
      bit rs1u, rs2u;
      if (!valid) return 1'b0;
      rs1u = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
      rs2u = (op == OP_ADD || op == OP_ADDW || op == OP_ST || op == OP_BR);
      return (rs1u && m_busy(rs1)) || (rs2u && m_busy(rs2)) ||
             (regwrite && pend[rd] && m_busy(rd));
   endfunction

   // One clock cycle: compare outputs against the model, take the edge,
   // then advance the model with the inputs that were applied.
   task automatic step(input bit do_chk);
      bit hz;
      #1;
      hz = m_hazard();
      if (do_chk) begin
         chk("noop",       {63'd0, noop},  {63'd0, hz});
         chk("stall",      {63'd0, stall}, {63'd0, hz});
         chk("pcwrite",    {63'd0, pcw},   {63'd0, !hz});
         chk("busy",       {32'd0, busy},  {32'd0, m_busyvec()});
         chk("stallcount", {48'd0, scnt},  m_scnt);
      end
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < NR; r++) begin
            ready[r] = 0;
            pend[r]  = 1'b0;
         end
         m_scnt = 0;
      end else begin
         if (hz && m_scnt < 65535) m_scnt++;
         if (wb) pend[wbrd] = 1'b0;
         if (valid && !hz && !flush && regwrite && rd != 0) begin
            if (varlat) begin
               pend[rd]  = 1'b1;
               ready[rd] = 0;
            end else begin
               ready[rd] = cyc + int'(lat) + 1;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      rst = 0; valid = 0; op = OP_ADDI; rs1 = 0; rs2 = 0; rd = 0;
      regwrite = 0; lat = 0; varlat = 0; flush = 0; wb = 0; wbrd = 0;
   endtask

   task automatic drive_id(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic w, input logic [2:0] l,
                           input logic v);
      valid = 1; op = o; rs1 = a; rs2 = b; rd = d; regwrite = w; lat = l; varlat = v;
   endtask

   initial begin
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_ADD, OP_ADDW, OP_ST, OP_BR, OP_ADDI, OP_LD, OP_JALR};
      // Directed vectors, applied with x5 and x3 holding pending VarLat entries
      vt[0]  = '{1'b1, OP_ADD,   5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
      vt[1]  = '{1'b1, OP_ADD,   5'd7, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
      vt[2]  = '{1'b1, OP_ADDI,  5'd7, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[3]  = '{1'b1, OP_LUI,   5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[4]  = '{1'b1, OP_AUIPC, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[5]  = '{1'b1, OP_JAL,   5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[6]  = '{1'b1, OP_ST,    5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
      vt[7]  = '{1'b1, OP_BR,    5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
      vt[8]  = '{1'b1, OP_ADDW,  5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
      vt[9]  = '{1'b1, OP_ADD,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[10] = '{1'b0, OP_ADD,   5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
      vt[11] = '{1'b1, OP_LD,    5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1};
      vt[12] = '{1'b1, OP_ADDI,  5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1};
      vt[13] = '{1'b1, OP_ADDI,  5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0};
      vt[14] = '{1'b1, OP_ADDI,  5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0};
      for (int r = 0; r < NR; r++) begin
         ready[r] = 0;
         pend[r]  = 1'b0;
      end

      // Reset and the cleared state
      idle();
      rst = 1;
      @(posedge clk); #1;
      step(0);
      step(1);
      rst = 0;
      #1;
      chk("rst_busy",    {32'd0, busy}, 64'd0);
      chk("rst_pcwrite", {63'd0, pcw},  64'd1);
      chk("rst_stall",   {63'd0, stall}, 64'd0);
      chk("rst_count",   {48'd0, scnt}, 64'd0);
      step(1);

      // Load-use: one bubble, then proceed, StallCount becomes 1
      drive_id(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 3'd1, 1'b0);
      step(1);
      drive_id(OP_ADD, 5'd5, 5'd7, 5'd6, 1'b1, 3'd0, 1'b0);
      #1;
      chk("lu_stall",   {63'd0, stall}, 64'd1);
      chk("lu_noop",    {63'd0, noop},  64'd1);
      chk("lu_pcwrite", {63'd0, pcw},   64'd0);
      step(1);
      #1;
      chk("lu_go",    {63'd0, stall}, 64'd0);
      chk("lu_count", {48'd0, scnt},  64'd1);
      step(1);

      // Latency 3: three stall cycles with x8 busy over the same cycles
      drive_id(OP_LD, 5'd1, 5'd0, 5'd8, 1'b1, 3'd3, 1'b0);
      step(1);
      drive_id(OP_ADD, 5'd8, 5'd0, 5'd6, 1'b1, 3'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("l3_stall", {63'd0, stall},   {63'd0, (i < 3)});
         chk("l3_busy8", {63'd0, busy[8]}, {63'd0, (i < 3)});
         step(1);
      end

      // Variable latency: stall until WB_Done on x9 releases it
      drive_id(OP_LD, 5'd1, 5'd0, 5'd9, 1'b1, 3'd0, 1'b1);
      step(1);
      drive_id(OP_ADD, 5'd9, 5'd0, 5'd6, 1'b1, 3'd0, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         #1;
         chk("var_stall", {63'd0, stall}, 64'd1);
         step(1);
      end
      wb = 1; wbrd = 5'd9;
      #1;
      chk("var_release", {63'd0, stall}, 64'd0);
      step(1);
      idle();

      // WAW against pending x3, then issue and WB on x3 in the same cycle
      drive_id(OP_LD, 5'd1, 5'd0, 5'd3, 1'b1, 3'd0, 1'b1);
      step(1);
      drive_id(OP_LD, 5'd0, 5'd0, 5'd3, 1'b1, 3'd0, 1'b1);
      #1;
      chk("waw_stall", {63'd0, stall}, 64'd1);
      step(1);
      wb = 1; wbrd = 5'd3;
      #1;
      chk("waw_wb_go", {63'd0, stall}, 64'd0);
      step(1);
      idle();
      #1;
      chk("waw_var_kept", {63'd0, busy[3]}, 64'd1);
      step(1);

      // Flushed hazard-free load creates no entry
      drive_id(OP_LD, 5'd0, 5'd0, 5'd10, 1'b1, 3'd2, 1'b0);
      flush = 1;
      step(1);
      idle();
      #1;
      chk("flush_no_entry", {63'd0, busy[10]}, 64'd0);
      step(1);

      // Table-driven source-usage / WAW / WB-forwarding vectors
      drive_id(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 3'd0, 1'b1);
      step(1);
      for (int i = 0; i < 15; i++) begin
         idle();
         valid = vt[i].valid; op = vt[i].op; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
         rd = vt[i].rd; regwrite = vt[i].regwrite; flush = vt[i].flush;
         wb = vt[i].wb; wbrd = vt[i].wbrd;
         #1;
         chk($sformatf("vec%0d", i), {63'd0, stall}, {63'd0, vt[i].exp_stall});
         step(1);
      end
      idle();

      // Saturate StallCount behind a pending x9, then reset mid-operation
      drive_id(OP_LD, 5'd1, 5'd0, 5'd9, 1'b1, 3'd0, 1'b1);
      step(1);
      drive_id(OP_ADD, 5'd9, 5'd0, 5'd6, 1'b1, 3'd0, 1'b0);
      for (int i = 0; i < 65540; i++) step(0);
      #1;
      chk("sat_count", {48'd0, scnt}, 64'hFFFF);
      step(1);
      rst = 1;
      step(1);
      rst = 0;
      #1;
      chk("rst2_busy",  {32'd0, busy}, 64'd0);
      chk("rst2_count", {48'd0, scnt}, 64'd0);
      chk("rst2_stall", {63'd0, stall}, 64'd0);
      step(1);
      idle();
      wb = 1; wbrd = 5'd9;
      step(1);
      idle();
      #1;
      chk("stale_wb", {32'd0, busy}, 64'd0);
      step(1);

      // Randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         rst      = ($urandom_range(0, 149) == 0);
         valid    = ($urandom_range(0, 3) != 0);
         op       = ops[$urandom_range(0, 9)];
         rs1      = 5'($urandom_range(0, 7));
         rs2      = 5'($urandom_range(0, 7));
         rd       = 5'($urandom_range(0, 7));
         regwrite = ($urandom_range(0, 3) != 0);
         lat      = 3'($urandom_range(0, 7));
         varlat   = ($urandom_range(0, 7) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         wb       = ($urandom_range(0, 2) == 0);
         wbrd     = 5'($urandom_range(0, 7));
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
